// File: rtl/ps2_event_queue.sv
// PS/2 scan-code decoder feeding a FWFT event FIFO of {brk, ext, code} entries.
// Define KBD_TYPEMATIC_FILTER_EN to drop typematic repeats of keys already held.
module ps2_event_queue #(
    parameter int DEPTH        = 8,
    parameter bit REPORT_BREAK = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    input  logic                       rx_error,
    input  logic                       rd_en,
    input  logic                       clear_flags,
    output logic [9:0]                 evt_data,
    output logic                       evt_valid,
    output logic [$clog2(DEPTH+1)-1:0] evt_count,
    output logic                       overflow,
    output logic                       err_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE} state_t;

    state_t     state, next_state;
    logic [2:0] skip, next_skip;
    logic       emit, emit_brk, emit_ext, restart;
    logic [7:0] emit_code;
    logic       is_prefix;

    assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0) || (rx_byte == 8'hE1);

    // A prefix arriving where a code byte is expected re-runs the IDLE decode on that byte.
    always_comb begin
        next_state = state;
        next_skip  = skip;
        emit       = 1'b0;
        emit_brk   = 1'b0;
        emit_ext   = 1'b0;
        emit_code  = rx_byte;
        restart    = 1'b0;
        if (rx_error) begin
            next_state = IDLE;
        end else if (rx_valid) begin
            case (state)
                GOT_E0: begin
                    if (rx_byte == 8'hF0) next_state = GOT_E0F0;
                    else if (is_prefix)   restart = 1'b1;
                    else begin
                        emit = 1'b1; emit_ext = 1'b1; next_state = IDLE;
                    end
                end
                GOT_F0: begin
                    if (is_prefix) restart = 1'b1;
                    else begin
                        emit = 1'b1; emit_brk = 1'b1; next_state = IDLE;
                    end
                end
                GOT_E0F0: begin
                    if (is_prefix) restart = 1'b1;
                    else begin
                        emit = 1'b1; emit_brk = 1'b1; emit_ext = 1'b1; next_state = IDLE;
                    end
                end
                PAUSE: begin
                    if (skip == 3'd1) begin
                        emit = 1'b1; emit_ext = 1'b1; emit_code = 8'hE1; next_state = IDLE;
                    end else begin
                        next_skip = skip - 3'd1;
                    end
                end
                default: ;
            endcase
            if (state == IDLE || restart) begin
                case (rx_byte)
                    8'hE0: next_state = GOT_E0;
                    8'hF0: next_state = GOT_F0;
                    8'hE1: begin next_state = PAUSE; next_skip = 3'd7; end
                    8'hFA, 8'hAA, 8'hFE, 8'hEE, 8'h00, 8'hFF: next_state = IDLE;
                    default: begin emit = 1'b1; next_state = IDLE; end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            skip  <= '0;
        end else begin
            state <= next_state;
            skip  <= next_skip;
        end
    end

    logic drop;
`ifdef KBD_TYPEMATIC_FILTER_EN
    logic [511:0] held;
    logic [8:0]   held_idx;
    assign held_idx = {emit_ext, emit_code};
    assign drop     = emit && !emit_brk && held[held_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    held <= '0;
        else if (emit) held[held_idx] <= !emit_brk;
    end
`else
    assign drop = 1'b0;
`endif

    logic          push, do_push, do_pop, full;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    assign push    = emit && !drop && (!emit_brk || REPORT_BREAK);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= {emit_brk, emit_ext, emit_code};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
            if (push && full && !do_pop) overflow <= 1'b1;
            else if (clear_flags)        overflow <= 1'b0;
            if (rx_error)         err_flag <= 1'b1;
            else if (clear_flags) err_flag <= 1'b0;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_count = count;
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
endmodule
